// File: rtl/score_pkg.sv
`default_nettype none
// score_pkg: shared types and constants for the score display path. Rev 1.0
package score_pkg;

  localparam int SCORE_WIDTH  = 16;
  localparam int SCORE_DIGITS = 5;
  localparam int SCORE_CNT_W  = $clog2(SCORE_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// bcd_digit_adjust: double-dabble digit correction, adds 3 when the digit is 5 or more. Rev 1.0
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/score_bcd.sv
`default_nettype none
// score_bcd: iterative double-dabble binary-to-BCD converter with a
// leading-zero blanking mask for the seven-segment driver. Rev 1.0
module score_bcd
  import score_pkg::*;
#(
  parameter int WIDTH  = SCORE_WIDTH,
  parameter int DIGITS = SCORE_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_start,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_SHW   = c_BCD_W + WIDTH;
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] c_BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              r_state, w_state_nxt;
  logic [c_SHW-1:0]    r_shift, w_shift_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [c_BCD_W-1:0]  r_bcd, w_bcd_nxt;
  logic [DIGITS-1:0]   r_blank, w_blank_nxt;
  logic                r_done, w_done_nxt;

  logic [c_BCD_W-1:0]  w_adj;
  logic [c_SHW-1:0]    w_pre;
  logic [c_SHW-1:0]    w_shifted;
  logic [DIGITS-1:0]   w_blank_scan;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_digit (r_shift[WIDTH + 4*g +: 4]),
        .o_digit (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // The adjusted top digit never reaches 8 for in-range inputs, so the bit shifted out is always 0.
  assign w_pre     = {w_adj, r_shift[WIDTH-1:0]};
  assign w_shifted = w_pre << 1;

  always_comb begin
    logic v_run;
    w_blank_scan = '0;
    v_run        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_run           = v_run & (r_shift[WIDTH + 4*i +: 4] == 4'd0);
      w_blank_scan[i] = v_run;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_blank_nxt = r_blank;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The cycle after DONE still counts as busy so the restart period is WIDTH+3.
        if (i_start && !r_done) begin
          w_shift_nxt = {{c_BCD_W{1'b0}}, i_value};
          w_cnt_nxt   = c_CNT_W'(WIDTH);
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        w_shift_nxt = w_shifted;
        w_cnt_nxt   = r_cnt - c_CNT_W'(1);
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_bcd_nxt   = r_shift[c_SHW-1:WIDTH];
        w_blank_nxt = w_blank_scan;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_blank <= c_BLANK_RST;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_blank <= w_blank_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_ready = (r_state == ST_IDLE) && !r_done;
  assign o_done  = r_done;
  assign o_bcd   = r_bcd;
  assign o_blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd.sv
`default_nettype none
// tb_score_bcd: directed and random checks of score_bcd against an arithmetic reference. Rev 1.0
module tb_score_bcd;

  localparam int W = 16;
  localparam int D = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [W-1:0]  i_value;
  logic          o_ready;
  logic          o_done;
  logic [4*D-1:0] o_bcd;
  logic [D-1:0]  o_blank;

  int total  = 0;
  int bad    = 0;
  int n_done = 0;

  logic [4*D-1:0] exp_bcd;
  logic [D-1:0]   exp_blank;

  score_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_value (i_value),
    .i_start (i_start),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_bcd   (o_bcd),
    .o_blank (o_blank)
  );

  always #5 clk = ~clk;

  // Reads the pre-edge value, so each high cycle of done is counted once.
  always @(posedge clk) if (o_done) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4*D-1:0] ref_bcd(input int v);
    int t;
    logic [4*D-1:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit i and everything above it are zero exactly when v < 10^i.
  function automatic logic [D-1:0] ref_blank(input int v);
    logic [D-1:0] m;
    int p;
    m = '0;
    p = 1;
    for (int i = 1; i < D; i++) begin
      p = p * 10;
      m[i] = (v < p);
    end
    return m;
  endfunction

  task automatic wait_done(output int lat, input bit interfere);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (interfere && lat == 5) begin
        i_start = 1'b1;
        i_value = 16'd7;
      end
      if (interfere && lat == 6) i_start = 1'b0;
      if (!o_done && lat < 40) begin
        check("bcd_hold", o_bcd, exp_bcd);
        check("ready_busy", o_ready, 1'b0);
      end
    end while (!o_done && lat < 40);
  endtask

  task automatic run_conv(input logic [W-1:0] v, input bit interfere);
    int lat;
    int d0;
    check("ready_idle", o_ready, 1'b1);
    i_value = v;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_value = 16'($urandom);
    d0 = n_done;
    wait_done(lat, interfere);
    check("latency", lat, 17);
    exp_bcd   = ref_bcd(int'(v));
    exp_blank = ref_blank(int'(v));
    check("bcd", o_bcd, exp_bcd);
    check("blank", o_blank, exp_blank);
    check("ready_in_done", o_ready, 1'b0);
    @(negedge clk);
    check("done_pulse", o_done, 1'b0);
    check("ready_back", o_ready, 1'b1);
    check("done_count", n_done - d0, 1);
  endtask

  initial begin
    int lat;
    int d0;
    logic [W-1:0] bnd [10];

    rst       = 1'b1;
    i_start   = 1'b0;
    i_value   = '0;
    exp_bcd   = '0;
    exp_blank = 5'b11110;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", o_ready, 1'b1);
    check("rst_done", o_done, 1'b0);
    check("rst_bcd", o_bcd, 20'h00000);
    check("rst_blank", o_blank, 5'b11110);
    d0 = n_done;
    repeat (50) @(negedge clk);
    check("idle_no_done", n_done - d0, 0);
    check("idle_bcd", o_bcd, 20'h00000);

    run_conv(16'd0, 1'b0);
    check("v0_bcd", o_bcd, 20'h00000);
    check("v0_blank", o_blank, 5'b11110);
    run_conv(16'd9, 1'b0);
    check("v9_bcd", o_bcd, 20'h00009);
    run_conv(16'd1000, 1'b0);
    check("v1000_blank", o_blank, 5'b10000);
    run_conv(16'd65535, 1'b0);
    check("vmax_bcd", o_bcd, 20'h65535);
    check("vmax_blank", o_blank, 5'b00000);

    // Back-to-back with start held high.
    check("b2b_ready", o_ready, 1'b1);
    i_value = 16'd12345;
    i_start = 1'b1;
    @(negedge clk);
    i_value = 16'd54321;
    d0 = n_done;
    wait_done(lat, 1'b0);
    check("b2b_lat1", lat, 17);
    exp_bcd   = ref_bcd(12345);
    exp_blank = ref_blank(12345);
    check("b2b_bcd1", o_bcd, exp_bcd);
    check("b2b_blank1", o_blank, exp_blank);
    @(negedge clk);
    check("b2b_ready_e18", o_ready, 1'b1);
    check("b2b_done_e18", o_done, 1'b0);
    @(negedge clk);
    check("b2b_accept_e19", o_ready, 1'b0);
    i_start = 1'b0;
    wait_done(lat, 1'b0);
    check("b2b_lat2", lat, 17);
    exp_bcd   = ref_bcd(54321);
    exp_blank = ref_blank(54321);
    check("b2b_bcd2", o_bcd, 20'h54321);
    check("b2b_blank2", o_blank, exp_blank);
    @(negedge clk);
    check("b2b_done_count", n_done - d0, 2);

    // Start and value changes while busy are ignored.
    run_conv(16'd31337, 1'b1);
    check("busy_bcd", o_bcd, 20'h31337);
    d0 = n_done;
    repeat (30) @(negedge clk);
    check("busy_no_extra", n_done - d0, 0);

    // Reset on E8 of a conversion.
    i_value = 16'd4321;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_bcd   = '0;
    exp_blank = 5'b11110;
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_bcd", o_bcd, exp_bcd);
    check("mid_rst_blank", o_blank, exp_blank);
    d0 = n_done;
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", n_done - d0, 0);
    run_conv(16'd42, 1'b0);
    check("v42_bcd", o_bcd, 20'h00042);
    check("v42_blank", o_blank, 5'b11100);

    // Reset and start together: reset wins.
    rst     = 1'b1;
    i_start = 1'b1;
    i_value = 16'd999;
    @(negedge clk);
    rst     = 1'b0;
    i_start = 1'b0;
    exp_bcd   = '0;
    exp_blank = 5'b11110;
    check("rst_start_ready", o_ready, 1'b1);
    check("rst_start_bcd", o_bcd, exp_bcd);
    d0 = n_done;
    repeat (25) @(negedge clk);
    check("rst_start_no_done", n_done - d0, 0);

    bnd = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999,
            16'd1000, 16'd9999, 16'd10000, 16'd65535};
    foreach (bnd[k]) run_conv(bnd[k], 1'b0);
    for (int n = 0; n < 200; n++) begin
      run_conv(16'($urandom_range(0, 65535)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
